// File: rtl/csi_packet_parser.sv
// CSI-2 packet-layer parser: header ECC check, VC filtering, payload streaming with keep, per-VC frame/line tracking.
// Define CSI_CRC_CHECK_EN to check the payload CRC-16; without it crc_error is tied low.

module csi_header_ecc (
    input  logic [23:0] data,
    output logic [7:0]  ecc
);
    // Parity-bit membership for each header bit; entry i belongs to data[i].
    localparam logic [23:0][5:0] COLS = {
        6'h3B, 6'h37, 6'h2F, 6'h1F, 6'h38, 6'h34, 6'h32, 6'h31,
        6'h2C, 6'h2A, 6'h29, 6'h26, 6'h25, 6'h23, 6'h1C, 6'h1A,
        6'h19, 6'h16, 6'h15, 6'h13, 6'h0E, 6'h0D, 6'h0B, 6'h07
    };

    always_comb begin
        ecc = 8'h00;
        for (int i = 0; i < 24; i++)
            if (data[i]) ecc[5:0] = ecc[5:0] ^ COLS[i];
    end
endmodule

module csi_packet_parser #(
    parameter int         NUM_LANES = 2,
    parameter logic [3:0] VC_MASK   = 4'b0001,
    parameter logic [5:0] VIDEO_DT  = 6'h2B
) (
    input  logic                   clock_p,
    input  logic                   reset,
    input  logic [8*NUM_LANES-1:0] lane_data,
    input  logic                   lane_valid,
    output logic                   header_valid,
    output logic [1:0]             virtual_channel,
    output logic [5:0]             data_type,
    output logic [15:0]            word_count,
    output logic                   ecc_error,
    output logic [8*NUM_LANES-1:0] payload_data,
    output logic [NUM_LANES-1:0]   payload_keep,
    output logic                   payload_valid,
    output logic                   payload_last,
    output logic                   payload_video,
    output logic                   frame_start,
    output logic                   frame_end,
    output logic                   line_start,
    output logic                   line_end,
    output logic [3:0]             in_frame,
    output logic [3:0]             in_line,
    output logic                   crc_error,
    output logic                   packet_done
);
    localparam int BW        = 8 * NUM_LANES;
    localparam int HDR_BEATS = 4 / NUM_LANES;
    localparam int HCW       = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
    localparam logic [HCW-1:0] HDR_LAST = HCW'(HDR_BEATS - 1);

    typedef enum logic [1:0] {S_HEADER, S_PAYLOAD, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [HCW-1:0]  hdr_cnt_q, hdr_cnt_d;
    logic [31:0]     hdr_q, hdr_cur;
    logic [16:0]     cnt_q, cnt_d, idx, wc17;
    logic [1:0]      vc_q, vc_d;
    logic [5:0]      dt_q, dt_d;
    logic [15:0]     wc_q, wc_d;
    logic [3:0]      in_frame_q, in_frame_d, in_line_q, in_line_d;
    logic [BW-1:0]   payload_data_q, payload_data_d;
    logic [NUM_LANES-1:0] keep_q, keep_d;
    logic header_valid_q, header_valid_d, ecc_error_q, ecc_error_d;
    logic frame_start_q, frame_start_d, frame_end_q, frame_end_d;
    logic line_start_q, line_start_d, line_end_q, line_end_d;
    logic payload_valid_q, payload_valid_d, payload_last_q, payload_last_d;
    logic payload_video_q, payload_video_d, packet_done_q, packet_done_d;
    logic crc_error_q, crc_error_d, crc_bad, ecc_bad;
    logic [7:0] ecc_calc;
    logic [1:0] hdr_vc;
    logic [5:0] hdr_dt;

    // Header buffer including the beat arriving this cycle, so decode happens on the final beat.
    always_comb begin
        hdr_cur = hdr_q;
        if (state_q == S_HEADER && lane_valid)
            hdr_cur[int'(hdr_cnt_q)*BW +: BW] = lane_data;
    end

    csi_header_ecc u_ecc (.data(hdr_cur[23:0]), .ecc(ecc_calc));

    assign ecc_bad = hdr_cur[31:24] != ecc_calc;
    assign hdr_vc  = hdr_cur[7:6];
    assign hdr_dt  = hdr_cur[5:0];
    assign wc17    = {1'b0, wc_q};

    always_comb begin
        state_d = state_q;  hdr_cnt_d = hdr_cnt_q;  cnt_d = cnt_q;
        vc_d = vc_q;  dt_d = dt_q;  wc_d = wc_q;
        in_frame_d = in_frame_q;  in_line_d = in_line_q;
        payload_data_d = payload_data_q;
        header_valid_d = 1'b0;  ecc_error_d = 1'b0;
        frame_start_d = 1'b0;  frame_end_d = 1'b0;
        line_start_d = 1'b0;  line_end_d = 1'b0;
        keep_d = '0;  payload_valid_d = 1'b0;
        payload_last_d = 1'b0;  payload_video_d = 1'b0;
        packet_done_d = 1'b0;  crc_error_d = 1'b0;
        idx = '0;
        case (state_q)
            S_HEADER: if (lane_valid) begin
                if (hdr_cnt_q != HDR_LAST) begin
                    hdr_cnt_d = hdr_cnt_q + 1'b1;
                end else begin
                    hdr_cnt_d = '0;
                    header_valid_d = 1'b1;
                    ecc_error_d = ecc_bad;
                    vc_d = hdr_vc;  dt_d = hdr_dt;  wc_d = hdr_cur[23:8];
                    state_d = S_DONE;
                    if (!ecc_bad && VC_MASK[hdr_vc]) begin
                        if (hdr_dt > 6'h0F) begin
                            state_d = S_PAYLOAD;
                            cnt_d = '0;
                        end else begin
                            case (hdr_dt)
                                6'h00: begin frame_start_d = 1'b1; in_frame_d[hdr_vc] = 1'b1; in_line_d[hdr_vc] = 1'b0; end
                                6'h01: begin frame_end_d = 1'b1; in_frame_d[hdr_vc] = 1'b0; in_line_d[hdr_vc] = 1'b0; end
                                6'h02: begin line_start_d = 1'b1; in_line_d[hdr_vc] = 1'b1; end
                                6'h03: begin line_end_d = 1'b1; in_line_d[hdr_vc] = 1'b0; end
                                default: ;
                            endcase
                        end
                    end
                end
            end
            S_PAYLOAD: if (lane_valid) begin
                // Bytes past WC are CRC or lane padding and never carry keep.
                for (int k = 0; k < NUM_LANES; k++) begin
                    idx = cnt_q + 17'(k);
                    keep_d[k] = idx < wc17;
                    if (idx + 17'd1 == wc17) payload_last_d = 1'b1;
                end
                payload_valid_d = |keep_d;
                payload_video_d = |keep_d && (dt_q == VIDEO_DT);
                payload_data_d  = lane_data;
                cnt_d = cnt_q + 17'(NUM_LANES);
                if (cnt_d >= wc17 + 17'd2) state_d = S_DONE;
            end
            S_DONE: begin
                packet_done_d = 1'b1;
                crc_error_d = crc_bad;
                state_d = S_HEADER;
            end
            default: state_d = S_HEADER;
        endcase
    end

`ifdef CSI_CRC_CHECK_EN
    logic [15:0] crc_q, crc_d, crc_rx_q, crc_rx_d;
    logic [16:0] cidx;

    // Reflected CCITT polynomial, LSB-first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        return r;
    endfunction

    always_comb begin
        crc_d = crc_q;  crc_rx_d = crc_rx_q;  cidx = '0;
        if (state_q == S_HEADER) begin
            crc_d = 16'hFFFF;
            crc_rx_d = 16'hFFFF;
        end else if (state_q == S_PAYLOAD && lane_valid) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                cidx = cnt_q + 17'(k);
                if (cidx < wc17)                crc_d = crc16_byte(crc_d, lane_data[8*k +: 8]);
                else if (cidx == wc17)          crc_rx_d[7:0]  = lane_data[8*k +: 8];
                else if (cidx == wc17 + 17'd1)  crc_rx_d[15:8] = lane_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clock_p) begin
        if (reset) begin
            crc_q <= 16'hFFFF;  crc_rx_q <= 16'hFFFF;
        end else begin
            crc_q <= crc_d;  crc_rx_q <= crc_rx_d;
        end
    end

    assign crc_bad = crc_q != crc_rx_q;
`else
    assign crc_bad = 1'b0;
`endif

    always_ff @(posedge clock_p) begin
        if (reset) begin
            state_q <= S_HEADER;  hdr_cnt_q <= '0;  hdr_q <= '0;  cnt_q <= '0;
            vc_q <= '0;  dt_q <= '0;  wc_q <= '0;
            in_frame_q <= '0;  in_line_q <= '0;
            payload_data_q <= '0;  keep_q <= '0;
            header_valid_q <= 1'b0;  ecc_error_q <= 1'b0;
            frame_start_q <= 1'b0;  frame_end_q <= 1'b0;
            line_start_q <= 1'b0;  line_end_q <= 1'b0;
            payload_valid_q <= 1'b0;  payload_last_q <= 1'b0;  payload_video_q <= 1'b0;
            packet_done_q <= 1'b0;  crc_error_q <= 1'b0;
        end else begin
            state_q <= state_d;  hdr_cnt_q <= hdr_cnt_d;  hdr_q <= hdr_cur;  cnt_q <= cnt_d;
            vc_q <= vc_d;  dt_q <= dt_d;  wc_q <= wc_d;
            in_frame_q <= in_frame_d;  in_line_q <= in_line_d;
            payload_data_q <= payload_data_d;  keep_q <= keep_d;
            header_valid_q <= header_valid_d;  ecc_error_q <= ecc_error_d;
            frame_start_q <= frame_start_d;  frame_end_q <= frame_end_d;
            line_start_q <= line_start_d;  line_end_q <= line_end_d;
            payload_valid_q <= payload_valid_d;  payload_last_q <= payload_last_d;
            payload_video_q <= payload_video_d;
            packet_done_q <= packet_done_d;  crc_error_q <= crc_error_d;
        end
    end

    assign header_valid    = header_valid_q;
    assign virtual_channel = vc_q;
    assign data_type       = dt_q;
    assign word_count      = wc_q;
    assign ecc_error       = ecc_error_q;
    assign payload_data    = payload_data_q;
    assign payload_keep    = keep_q;
    assign payload_valid   = payload_valid_q;
    assign payload_last    = payload_last_q;
    assign payload_video   = payload_video_q;
    assign frame_start     = frame_start_q;
    assign frame_end       = frame_end_q;
    assign line_start      = line_start_q;
    assign line_end        = line_end_q;
    assign in_frame        = in_frame_q;
    assign in_line         = in_line_q;
    assign crc_error       = crc_error_q;
    assign packet_done     = packet_done_q;
endmodule
